ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: the transmit end of the PS/2 link.
//  It sends one command byte to the keyboard, for example 0xED set-LEDs or 0xF4 enable.

---
 rtl/ps2_host_tx.sv | 153 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start bit, 8 data + odd parity + stop shifted on device clock falls, then ACK sample.
// Inputs pass through 2-FF synchronizers; a watchdog aborts the frame if the device stops clocking.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic       CLOCK_50,
   input  logic       reset_n,
   input  logic       send,
   input  logic [7:0] tx_data,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_ok
);

   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE
   } state_t;

   state_t        state_q;
   logic          clk_meta_q, clk_sync_q, clk_prev_q;
   logic          dat_meta_q, dat_sync_q;
   logic [IW-1:0] inh_cnt_q;
   logic [WW-1:0] wdog_q, wdog_d;
   logic [9:0]    shift_q;
   logic [3:0]    bit_cnt_q;
   logic          ack_q;
   logic          clk_oe_q, dat_oe_q, busy_q, done_q, ack_ok_q;
   logic          fall, lines_idle, watched, wd_fire;

   assign fall       = clk_prev_q & ~clk_sync_q;
   assign lines_idle = clk_sync_q & dat_sync_q;
   assign watched    = (state_q == S_REQ) || (state_q == S_SHIFT) ||
                       (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
   assign wdog_d     = fall ? '0 : wdog_q + WW'(1);
   // A completed frame in WAIT_IDLE wins over a simultaneous watchdog expiry.
   assign wd_fire    = watched && !fall && (wdog_q == WW'(TIMEOUT_CYCLES - 1)) &&
                       !((state_q == S_WAIT_IDLE) && lines_idle);

   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         clk_meta_q <= 1'b1;
         clk_sync_q <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_meta_q <= 1'b1;
         dat_sync_q <= 1'b1;
         inh_cnt_q  <= '0;
         wdog_q     <= '0;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         ack_q      <= 1'b0;
         clk_oe_q   <= 1'b0;
         dat_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ack_ok_q   <= 1'b0;
      end else begin
         clk_meta_q <= ps2_clk_in;
         clk_sync_q <= clk_meta_q;
         clk_prev_q <= clk_sync_q;
         dat_meta_q <= ps2_dat_in;
         dat_sync_q <= dat_meta_q;
         done_q     <= 1'b0;
         ack_ok_q   <= 1'b0;

         if (wd_fire) begin
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_IDLE;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (send) begin
                     shift_q   <= {1'b1, ~^tx_data, tx_data};
                     ack_q     <= 1'b0;
                     inh_cnt_q <= '0;
                     clk_oe_q  <= 1'b1;
                     busy_q    <= 1'b1;
                     state_q   <= S_INHIBIT;
                  end
               end
               S_INHIBIT: begin
                  if (inh_cnt_q == IW'(INHIBIT_CYCLES - 1)) begin
                     clk_oe_q <= 1'b0;
                     dat_oe_q <= 1'b1;
                     wdog_q   <= '0;
                     state_q  <= S_REQ;
                  end else begin
                     inh_cnt_q <= inh_cnt_q + IW'(1);
                  end
               end
               S_REQ: begin
                  wdog_q <= wdog_d;
                  if (fall) begin
                     dat_oe_q  <= ~shift_q[0];
                     shift_q   <= {1'b0, shift_q[9:1]};
                     bit_cnt_q <= 4'd1;
                     state_q   <= S_SHIFT;
                  end
               end
               S_SHIFT: begin
                  wdog_q <= wdog_d;
                  if (fall) begin
                     dat_oe_q  <= ~shift_q[0];
                     shift_q   <= {1'b0, shift_q[9:1]};
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                     if (bit_cnt_q == 4'd9) state_q <= S_ACK;
                  end
               end
               S_ACK: begin
                  wdog_q <= wdog_d;
                  if (fall) begin
                     ack_q   <= ~dat_sync_q;
                     state_q <= S_WAIT_IDLE;
                  end
               end
               S_WAIT_IDLE: begin
                  wdog_q <= wdog_d;
                  if (lines_idle) begin
                     done_q   <= 1'b1;
                     ack_ok_q <= ack_q;
                     busy_q   <= 1'b0;
                     state_q  <= S_IDLE;
                  end
               end
               default: begin
                  clk_oe_q <= 1'b0;
                  dat_oe_q <= 1'b0;
                  busy_q   <= 1'b0;
                  state_q  <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign ps2_clk_oe = clk_oe_q;
   assign ps2_dat_oe = dat_oe_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign ack_ok     = ack_ok_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a device-side clocking model and a per-cycle output checker.
`timescale 1ns/1ps
module tb_ps2_host_tx;
   localparam int INH = 20;
   localparam int TMO = 200;

   logic       clk = 1'b0;
   logic       reset_n, send;
   logic [7:0] tx_data;
   logic       bfm_clk = 1'b1, bfm_dat = 1'b1;
   logic       ps2_clk_in, ps2_dat_in;
   logic       ps2_clk_oe, ps2_dat_oe, busy, done, ack_ok;

   always #5 clk = ~clk;

   // Open-drain lines: low if either side pulls them.
   assign ps2_clk_in = bfm_clk & ~ps2_clk_oe;
   assign ps2_dat_in = bfm_dat & ~ps2_dat_oe;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .CLOCK_50  (clk),
      .reset_n   (reset_n),
      .send      (send),
      .tx_data   (tx_data),
      .ps2_clk_in(ps2_clk_in),
      .ps2_dat_in(ps2_dat_in),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_dat_oe(ps2_dat_oe),
      .busy      (busy),
      .done      (done),
      .ack_ok    (ack_ok)
   );

   int n_checks = 0, n_fail = 0;
   int cyc = 0;
   int exp_ack_q[$];
   int done_cnt = 0, inh_run = 0, low_run = 0, last_gap = -1;
   int e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Line order of a frame: bit i of the result is the i-th bit put on the wire after the start bit.
   function automatic logic [9:0] frame_of(input logic [7:0] b);
      logic par;
      par = ($countones(b) % 2) == 0;
      return {1'b1, par, b};
   endfunction

   always @(negedge clk) begin
      chk("ack_ok_outside_done", 32'(ack_ok & ~done), 0);
      chk("busy_in_done_cycle", 32'(done & busy), 0);
      chk("oe_while_idle", 32'(~busy & (ps2_clk_oe | ps2_dat_oe)), 0);
      chk("both_oe", 32'(ps2_clk_oe & ps2_dat_oe), 0);
      if (done) begin
         done_cnt++;
         if (exp_ack_q.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            e = exp_ack_q.pop_front();
            chk("ack_ok", 32'(ack_ok), 32'(e));
         end
      end
      if (ps2_clk_oe) inh_run++;
      else if (inh_run != 0) begin
         chk("inhibit_len", 32'(inh_run), INH);
         inh_run = 0;
      end
      if (!busy) low_run++;
      else begin
         if (low_run != 0) last_gap = low_run;
         low_run = 0;
      end
   end

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (ps2_dat_oe && !ps2_clk_oe) begin
            ok = 1'b1;
            break;
         end
      end
      chk("req_seen", 32'(ok), 1);
   endtask

   // Device model: 40-cycle clock period, reads each bit at the rising edge after its fall.
   task automatic bfm_frame(input int nfalls, input bit ack, output logic [9:0] bits);
      bit ok;
      bits = '0;
      wait_req(ok);
      if (ok) begin
         repeat (20) @(negedge clk);
         chk("start_bit", 32'(ps2_dat_in), 0);
         for (int k = 1; k <= nfalls; k++) begin
            bfm_clk = 1'b0;
            repeat (20) @(negedge clk);
            bfm_clk = 1'b1;
            if (k <= 10) bits[k-1] = ps2_dat_in;
            if (k == 10 && nfalls == 11) bfm_dat = ~ack;
            if (k == 11) bfm_dat = 1'b1;
            repeat (20) @(negedge clk);
         end
      end
   endtask

   task automatic do_send(input logic [7:0] b);
      @(negedge clk);
      tx_data = b;
      send    = 1'b1;
      @(negedge clk);
      send    = 1'b0;
      tx_data = 8'h00;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      logic [9:0] bits, bits2;
      int d0, t0, t1;
      bit ok;
      reset_n = 1'b0;
      send    = 1'b0;
      tx_data = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_ack_ok", 32'(ack_ok), 0);
      chk("rst_clk_oe", 32'(ps2_clk_oe), 0);
      chk("rst_dat_oe", 32'(ps2_dat_oe), 0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // 1: 0xF4 acknowledged
      d0 = done_cnt;
      exp_ack_q.push_back(1);
      do_send(8'hF4);
      bfm_frame(11, 1'b1, bits);
      chk("f4_bits_literal", 32'(bits), 32'(10'b10_1111_0100));
      chk("f4_bits_model", 32'(bits), 32'(frame_of(8'hF4)));
      chk("f4_done_cnt", 32'(done_cnt), 32'(d0 + 1));

      // 2: 0xED not acknowledged
      d0 = done_cnt;
      exp_ack_q.push_back(0);
      do_send(8'hED);
      bfm_frame(11, 1'b0, bits);
      chk("ed_bits_literal", 32'(bits), 32'(10'b11_1110_1101));
      chk("ed_bits_model", 32'(bits), 32'(frame_of(8'hED)));
      chk("ed_done_cnt", 32'(done_cnt), 32'(d0 + 1));

      // 3: device silent -> watchdog
      exp_ack_q.push_back(0);
      do_send(8'hA5);
      wait_req(ok);
      t0 = cyc;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      t1 = cyc;
      chk("timeout_done_seen", 32'(ok), 1);
      chk("timeout_latency", 32'(t1 - t0), TMO);
      chk("timeout_clk_oe", 32'(ps2_clk_oe), 0);
      chk("timeout_dat_oe", 32'(ps2_dat_oe), 0);
      @(negedge clk);
      chk("after_timeout_oe", 32'(ps2_clk_oe | ps2_dat_oe), 0);
      chk("after_timeout_busy", 32'(busy), 0);

      // 4: send pulsed mid-frame is ignored
      d0 = done_cnt;
      exp_ack_q.push_back(1);
      do_send(8'h3C);
      fork
         bfm_frame(11, 1'b1, bits);
         begin
            repeat (200) @(negedge clk);
            send    = 1'b1;
            tx_data = 8'h00;
            @(negedge clk);
            send    = 1'b0;
         end
      join
      repeat (30) @(negedge clk);
      chk("midsend_bits", 32'(bits), 32'(frame_of(8'h3C)));
      chk("midsend_done_cnt", 32'(done_cnt), 32'(d0 + 1));

      // 5: reset during SHIFT aborts silently
      d0 = done_cnt;
      do_send(8'h5A);
      bfm_frame(4, 1'b1, bits);
      reset_n = 1'b0;
      @(negedge clk);
      chk("abort_oe", 32'(ps2_clk_oe | ps2_dat_oe), 0);
      chk("abort_busy", 32'(busy), 0);
      reset_n = 1'b1;
      repeat (50) @(negedge clk);
      chk("abort_no_done", 32'(done_cnt), 32'(d0));
      exp_ack_q.push_back(1);
      do_send(8'h96);
      bfm_frame(11, 1'b1, bits);
      chk("post_abort_bits", 32'(bits), 32'(frame_of(8'h96)));
      chk("post_abort_done_cnt", 32'(done_cnt), 32'(d0 + 1));

      // 6: send held high -> back-to-back frames
      d0 = done_cnt;
      exp_ack_q.push_back(1);
      exp_ack_q.push_back(1);
      @(negedge clk);
      tx_data = 8'hC3;
      send    = 1'b1;
      fork
         begin
            bfm_frame(11, 1'b1, bits);
            bfm_frame(11, 1'b1, bits2);
         end
         begin
            repeat (5) @(negedge clk);
            tx_data = 8'h81;
            ok = 1'b0;
            for (int i = 0; i < 1500; i++) begin
               @(negedge clk);
               if (done) begin
                  ok = 1'b1;
                  break;
               end
            end
            chk("b2b_first_done", 32'(ok), 1);
            @(negedge clk);
            send    = 1'b0;
            tx_data = 8'h00;
         end
      join
      repeat (30) @(negedge clk);
      chk("b2b_bits1", 32'(bits), 32'(frame_of(8'hC3)));
      chk("b2b_bits2", 32'(bits2), 32'(frame_of(8'h81)));
      chk("b2b_busy_gap", 32'(last_gap), 1);
      chk("b2b_done_cnt", 32'(done_cnt), 32'(d0 + 2));
      chk("b2b_idle_after", 32'(busy), 0);

      chk("pending_dones", 32'(exp_ack_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
